// File: rtl/sm_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with PWM brightness, anti-ghost blanking,
// leading-zero suppression and tear-free double-buffered display data.

module sm_seg_hex7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

module sm_seg_scan_ctrl #(
  parameter int STEP  = 64,
  parameter int BLANK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        we,
  input  logic [15:0] wdata,
  input  logic [3:0]  bright,
  input  logic        lz_en,
  output logic [3:0]  anode,
  output logic [6:0]  seg_n,
  output logic [15:0] gpio_out,
  output logic        frame_done
);
  localparam int NUM_DIG = 4;
  localparam int SLOT    = 16 * STEP;
  localparam int CW      = $clog2(SLOT);
  localparam int LW      = CW + 1;

  logic [CW-1:0] c;
  logic [1:0]    d;
  logic [15:0]   p_q, a_q;
  logic          en_q;

  logic                       slot_end, frame_end, en_rise, load_a;
  logic [NUM_DIG-1:0][6:0]    seg_dig;
  logic [NUM_DIG-1:0]         sup;
  logic [LW-1:0]              lim;
  logic                       lit;
  logic [3:0]                 anode_nxt;
  logic [6:0]                 seg_n_nxt;

  assign slot_end  = (c == CW'(SLOT - 1));
  assign frame_end = en && slot_end && (d == 2'd3);
  assign en_rise   = en && !en_q;
  assign load_a    = frame_end || en_rise;

  // Per-digit decode and suppression; a digit is blank when it and all higher nibbles are zero.
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
    sm_seg_hex7 u_hex (.nib(a_q[4*k +: 4]), .seg(seg_dig[k]));
    if (k == 0) begin : g_d0
      assign sup[k] = 1'b0;
    end else begin : g_dk
      assign sup[k] = lz_en && (a_q[15:4*k] == '0);
    end
  end

  assign lim = LW'((32'(bright) + 32'd1) * 32'(STEP));
  assign lit = en && (32'(c) >= BLANK) && ({1'b0, c} < lim) && !sup[d];

  assign anode_nxt = lit ? (4'b0001 << d) : 4'b0000;
  assign seg_n_nxt = lit ? ~seg_dig[d] : 7'h7F;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c    <= '0;
      d    <= '0;
      p_q  <= '0;
      a_q  <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= en;
      if (we) p_q <= wdata;
      // A same-cycle write wins over the pending buffer at a frame boundary.
      if (load_a) a_q <= we ? wdata : p_q;
      if (!en) begin
        c <= '0;
        d <= '0;
      end else if (slot_end) begin
        c <= '0;
        d <= d + 2'd1;
      end else begin
        c <= c + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode      <= 4'b0000;
      seg_n      <= 7'h7F;
      gpio_out   <= 16'h00FE;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_nxt;
      seg_n      <= seg_n_nxt;
      gpio_out   <= {4'b0000, anode_nxt, seg_n_nxt, 1'b0};
      frame_done <= frame_end;
    end
  end
endmodule

// File: doc/sm_seg_scan_ctrl.md
SM_SEG_SCAN_CTRL -- requirements
Module: sm_seg_scan_ctrl

Interface
REQ-001 Parameter STEP, default 64: cycles per brightness step; slot length SLOT = 16*STEP cycles.
REQ-002 Parameter BLANK, default 4: anti-ghosting dead cycles at the start of every digit slot; legal range 0..SLOT-1.
REQ-003 clk  in  1  single clock; every register is on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  scan enable; 0 = display dark and scan held.
REQ-006 we  in  1  write strobe for wdata, one-cycle.
REQ-007 wdata  in  16  four hex digits; [3:0] = digit 0 ... [15:12] = digit 3.
REQ-008 bright  in  4  brightness; on-window per slot is (bright+1) steps.
REQ-009 lz_en  in  1  leading-zero suppression enable.
REQ-010 anode  out  4  one-hot active-high digit select; 0 = all off.
REQ-011 seg_n  out  7  active-low segments; [0]=a ... [6]=g.
REQ-012 gpio_out  out  16  packed {4'b0000, anode, seg_n, 1'b0} for the GPIO output port.
REQ-013 frame_done  out  1  one-cycle pulse at the end of each digit-3 slot.

Function
REQ-014 Internal state: slot counter c (0..SLOT-1), digit index d (0..3), pending register P[15:0], active register A[15:0].
REQ-015 With en=1, c increments every cycle. At c=SLOT-1, c wraps to 0 and d increments modulo 4.
REQ-016 Frame boundary: the cycle where c=SLOT-1 and d=3. At this cycle A loads P, or loads wdata if we=1 in the same cycle.
REQ-017 Write when not at a frame boundary: we=1 loads P with wdata; A is unchanged until the next frame boundary (no tearing). Back-to-back writes keep the last value.
REQ-018 Digit lit condition: BLANK <= c < (bright+1)*STEP. If (bright+1)*STEP <= BLANK, the digit is never lit.
REQ-019 Lit: anode = 1<<d; seg_n = ~hex7(A nibble d).
REQ-020 Unlit: anode = 4'b0000 and seg_n = 7'h7F.
REQ-021 hex7 uses standard a..g encodings: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-022 Leading-zero suppression: with lz_en=1, digit k (k=3..1) is unlit whenever nibbles k..3 of A are all zero. Digit 0 is never suppressed. The slot timing of a suppressed digit is unchanged.
REQ-023 anode, seg_n, gpio_out and frame_done are registered. They reflect the state (c, d, A, bright, lz_en) of the previous cycle, i.e. 1-cycle latency.
REQ-024 frame_done = 1 in the cycle after the frame boundary cycle; 0 otherwise.
REQ-025 en=0: c and d are forced to 0 and the outputs go dark on the next edge; frame_done stays 0. P still accepts writes.
REQ-026 en rising (0 to 1): treated as a frame boundary. A loads P (or wdata if we=1 in that cycle), and the scan starts at d=0, c=0.
REQ-027 bright may change at any cycle and takes effect immediately on the lit comparison. Slot length never changes.
REQ-028 Exactly one anode is ever high at a time; anode switches only through an all-off cycle whenever BLANK>=1.

Reset
REQ-029 rst_n=0 asynchronously forces c=0, d=0, P=0, A=0, anode=0, seg_n=7'h7F, gpio_out=16'h00FE, frame_done=0.
REQ-030 After rst_n deasserts with en=1, the first scan starts at d=0, c=0. Reset asserted mid-slot or mid-write discards the write; the next frame shows A=0.

Verification (STEP=4, BLANK=2; SLOT=64, frame=256 cycles)
REQ-031 Reset release with en=1, no writes, lz_en=0, bright=15 -> c=0,1 dark; from c=2 to 63 of each slot: anode=0001, seg_n=7'h40 (digit 0). Slots for digits 1..3 follow with anode 0010/0100/1000 and all digits show 0. frame_done pulses every 256 cycles.
REQ-032 Write wdata=16'h1234 mid digit-1 slot -> display unchanged until the frame boundary; next frame shows digit 0 seg_n=~7'h66 ... digit 3 seg_n=~7'h06.
REQ-033 bright=0 -> lit only at c=2,3 of each slot. bright=7 -> lit at c=2..31. Check the one-hot anode and the dark gap between slots.
REQ-034 lz_en=1, A=16'h0050 -> digits 3 and 2 dark, digit 1 shows 5 (seg_n=~7'h6D), digit 0 shows 0. A=16'h0000 -> only digit 0 lit.
REQ-035 we=1 with wdata=16'hABCD on the frame-boundary cycle -> the immediately following frame shows ABCD. Then drop en for 10 cycles -> anode=0 and frame_done=0. Re-raise en -> scan restarts at digit 0, c=0.
REQ-036 rst_n pulsed low during a lit cycle -> anode=0 and gpio_out=16'h00FE asynchronously. After release the display shows 0000.
